crossbar_arbiter: RTL

- Round-robin arbiter for the shared crossbar bus that connects NUM_PORTS crossbar bridges, one per wrapped router.
- Each bridge raises request. The arbiter issues a one-hot grant, then monitors the shared bus handshake to follow the packet: header, size, then payload.
- Grant is held until the last payload flit is accepted. It is revoked early on request withdrawal or on a stall timeout.
- Sits beside the crossbar bus at cluster level, one instance per crossbar.

---
 rtl/HeMPS_defaults.sv | 28 ++
 rtl/rr_priority_select.sv | 39 +++
 rtl/crossbar_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/HeMPS_defaults.sv
// Shared defaults for the crossbar wrapper: flit width, flit type, arbiter
// state encoding, default stall timeout and a small index helper.
package HeMPS_defaults;

    localparam int TAM_FLIT            = 32;
    localparam int ARB_TIMEOUT_DEFAULT = 1024;

    typedef logic [TAM_FLIT-1:0] regflit;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SIZE,
        PAYLOAD,
        RELEASE
    } arb_state_t;

    // Adds an offset to a port index and wraps it back into 0..modulus-1.
    function automatic int wrap_add(input int base, input int offset, input int modulus);
        int sum;
        sum = base + offset;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: the first set request bit at or above the
// pointer wins, wrapping around past the top port. Reusable by any scheduler.
module rr_priority_select
    import HeMPS_defaults::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [IW-1:0]        pointer,
    output logic [NUM_PORTS-1:0] select_onehot,
    output logic [IW-1:0]        select_index,
    output logic                 valid
);

    logic [IW-1:0] cand [NUM_PORTS];

    // Candidate port for each search step, in priority order starting at the pointer
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = IW'(wrap_add(int'(pointer), i, NUM_PORTS));
        end
    end

    // Take the first requesting candidate; later requesters are masked off
    always_comb begin
        select_onehot = '0;
        select_index  = '0;
        valid         = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!valid && request[cand[i]]) begin
                valid                  = 1'b1;
                select_index           = cand[i];
                select_onehot[cand[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// Round-robin owner of the shared crossbar bus. Grants one bridge, follows its
// packet (header, size, payload) from the bus handshake, and releases the bus
// on the last flit, on request withdrawal, or after a stall timeout.
module crossbar_arbiter
    import HeMPS_defaults::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int FLIT_WIDTH = TAM_FLIT,
    parameter int TIMEOUT    = ARB_TIMEOUT_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         request,
    output logic [NUM_PORTS-1:0]         grant,
    input  logic                         bus_tx,
    input  logic                         bus_credit,
    input  logic [FLIT_WIDTH-1:0]        bus_data,
    output logic                         busy,
    output logic [$clog2(NUM_PORTS)-1:0] owner,
    output logic                         timeout_err
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t              state_q, state_d;
    logic [NUM_PORTS-1:0]    grant_q, grant_d;
    logic                    busy_q, busy_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [FLIT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [CW-1:0]           stall_q, stall_d;
    logic                    timeout_err_q, timeout_err_d;

    logic                    transfer;
    logic                    owner_req;
    logic [IW-1:0]           next_ptr;
    logic [IW-1:0]           sel_ptr;
    logic [NUM_PORTS-1:0]    sel_onehot;
    logic [IW-1:0]           sel_index;
    logic                    sel_valid;

    // Bus handshake decode and the pointer the selector should search from
    always_comb begin
        transfer  = bus_tx & bus_credit;
        owner_req = request[owner_q];
        next_ptr  = (owner_q == IW'(NUM_PORTS - 1)) ? '0 : owner_q + IW'(1);
        // The release cycle already arbitrates with the advanced pointer, so
        // exactly one idle bus cycle separates consecutive grants
        sel_ptr   = (state_q == RELEASE) ? next_ptr : ptr_q;
    end

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_select (
        .request       (request),
        .pointer       (sel_ptr),
        .select_onehot (sel_onehot),
        .select_index  (sel_index),
        .valid         (sel_valid)
    );

    // Next-state logic: grant, packet tracking, abort and stall timeout
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        stall_d       = stall_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_onehot;
                    owner_d = sel_index;
                    stall_d = '0;
                    state_d = HEADER;
                end
            end

            HEADER, SIZE, PAYLOAD: begin
                if (!owner_req) begin
                    grant_d = '0;
                    stall_d = '0;
                    state_d = RELEASE;
                end else if (transfer) begin
                    stall_d = '0;
                    if (state_q == HEADER) begin
                        state_d = SIZE;
                    end else if (state_q == SIZE) begin
                        remaining_d = bus_data;
                        if (bus_data == '0) begin
                            grant_d = '0;
                            state_d = RELEASE;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        if (remaining_q == FLIT_WIDTH'(1)) begin
                            grant_d = '0;
                            state_d = RELEASE;
                        end
                        remaining_d = remaining_q - FLIT_WIDTH'(1);
                    end
                end else if (stall_q == CW'(TIMEOUT - 1)) begin
                    grant_d       = '0;
                    stall_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end

            RELEASE: begin
                ptr_d   = next_ptr;
                stall_d = '0;
                if (sel_valid) begin
                    grant_d = sel_onehot;
                    owner_d = sel_index;
                    state_d = HEADER;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = |grant_d;
    end

    // State and registered outputs; reset dominates everything, even mid-packet
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            owner_q       <= '0;
            ptr_q         <= '0;
            remaining_q   <= '0;
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            remaining_q   <= remaining_d;
            stall_q       <= stall_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule
